// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-ported data memory
// between the CPU load/store port (0) and the debug/loader port (1).
// One word access is in flight at a time; each access takes an IDLE
// sample cycle followed by a single ACCESS cycle on the memory pins.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   reqN, weN             access request and write/read select for port N
//   addrN, wdataN         byte address (low 2 bits ignored) and write data
//   gntN                  pulse: port N's access is on the memory pins
//   doneN, errN           pulse: access complete / address out of range
//   rdataN                last read result for port N
//   mwr, moe, ma, mwd     memory write enable, output enable, address, data
//   mrd                   memory read data, combinational from ma
module mem_arbiter #(
   parameter int unsigned MEM_WORDS = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req0,
   input  logic        we0,
   input  logic [31:0] addr0,
   input  logic [31:0] wdata0,
   input  logic        req1,
   input  logic        we1,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        done0,
   output logic        done1,
   output logic        err0,
   output logic        err1,
   output logic [31:0] rdata0,
   output logic [31:0] rdata1,
   output logic        mwr,
   output logic        moe,
   output logic [31:0] ma,
   output logic [31:0] mwd,
   input  logic [31:0] mrd
);

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic        last_q, last_d;
   logic        win_c;
   logic        load_c;
   logic        in_range_c;

   logic        txn_we_q;
   logic [31:0] txn_addr_q;
   logic [31:0] txn_wdata_q;
   logic        done0_q, done1_q;
   logic        err0_q, err1_q;
   logic [31:0] rdata0_q, rdata1_q;

   // Full 30-bit word index compare, zero-extended to the parameter width
   assign in_range_c = ({2'b00, txn_addr_q[31:2]} < MEM_WORDS);

   // State register; last starts at 1 so port 0 wins the first tie
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   // Next-state and winner selection
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      win_c   = 1'b0;
      load_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               // Tie goes to the port that did not win last time
               win_c   = (req0 && req1) ? ~last_q : req1;
               last_d  = win_c;
               load_c  = 1'b1;
               state_d = ACCESS;
            end
         end
         ACCESS:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Grant decode and memory pins; enables gated by reset so a reset
   // landing in ACCESS never issues a write
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      mwr  = 1'b0;
      moe  = 1'b0;
      ma   = '0;
      mwd  = '0;
      if (state_q == ACCESS) begin
         gnt0 = ~last_q;
         gnt1 = last_q;
         mwr  = txn_we_q & in_range_c & ~reset;
         moe  = ~txn_we_q & ~reset;
         ma   = txn_addr_q;
         mwd  = txn_wdata_q;
      end
   end

   // Transaction capture and per-port completion registers
   always_ff @(posedge clock) begin
      if (reset) begin
         txn_we_q    <= 1'b0;
         txn_addr_q  <= '0;
         txn_wdata_q <= '0;
         done0_q     <= 1'b0;
         done1_q     <= 1'b0;
         err0_q      <= 1'b0;
         err1_q      <= 1'b0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
      end else begin
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         err0_q  <= 1'b0;
         err1_q  <= 1'b0;
         if (load_c) begin
            txn_we_q    <= win_c ? we1    : we0;
            txn_addr_q  <= win_c ? addr1  : addr0;
            txn_wdata_q <= win_c ? wdata1 : wdata0;
         end
         if (state_q == ACCESS) begin
            if (!last_q) begin
               done0_q <= 1'b1;
               err0_q  <= ~in_range_c;
               if (!txn_we_q) rdata0_q <= in_range_c ? mrd : 32'h0;
            end else begin
               done1_q <= 1'b1;
               err1_q  <= ~in_range_c;
               if (!txn_we_q) rdata1_q <= in_range_c ? mrd : 32'h0;
            end
         end
      end
   end

   assign done0  = done0_q;
   assign done1  = done1_q;
   assign err0   = err0_q;
   assign err1   = err1_q;
   assign rdata0 = rdata0_q;
   assign rdata1 = rdata1_q;

endmodule
